// File: rtl/pe_sqrt_sched.sv
// ---------------------------------------------------------------------------
// pe_sqrt_sched
//
// Issue/collect stage in front of the iterative float32 square-root core
// (squareroot_f32_approximation). Operands arrive on a valid/ready port and
// are buffered in a small circular FIFO. One operand at a time is popped,
// driven onto core_a, and the core is started by holding core_rst high for
// START_CYCLES cycles and then releasing it. When the core raises core_rdy
// its result is captured and held on the valid/ready result port until it
// is consumed. A watchdog aborts a core run that takes TIMEOUT WAIT cycles.
//
// Optional feature (macro PE_SQRT_SCHED_BYPASS_EN):
//   When defined, special operands (+-0, subnormals, negatives, +inf, NaN)
//   are resolved in IDLE and go straight to HOLD without starting the core.
//   When undefined, every operand is run through the core.
//
// Parameters:
//   FIFO_DEPTH   operand FIFO entries (power of two, >= 2)
//   START_CYCLES cycles core_rst is held high per launch (>= 1)
//   TIMEOUT      WAIT cycles before a run is aborted (>= 2)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand valid
//   in_ready   operand accepted when in_valid & in_ready
//   in_a       float32 operand
//   core_a     operand to the core
//   core_rst   core reset; high = core idle or restarting
//   core_rdy   core result ready
//   core_sqrt  core result
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   out_sqrt   float32 result
//   out_err    result came from a watchdog abort
//   busy       FSM not idle, or FIFO not empty
// ---------------------------------------------------------------------------
module pe_sqrt_sched #(
   parameter int FIFO_DEPTH   = 4,
   parameter int START_CYCLES = 1,
   parameter int TIMEOUT      = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   output logic [31:0] core_a,
   output logic        core_rst,
   input  logic        core_rdy,
   input  logic [31:0] core_sqrt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sqrt,
   output logic        out_err,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   // Counters only ever hold values up to (limit - 1).
   localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [31:0] QNAN = 32'h7fc0_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_HOLD
   } state_t;

   // ------------------------------------------------------------------
   // Operand FIFO
   // ------------------------------------------------------------------
   logic [31:0] mem_q [FIFO_DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic        push;
   logic        pop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

   // in_ready is held low during reset so nothing is accepted while the
   // FIFO is being flushed.
   assign in_ready = !rst && !fifo_full;
   assign push     = in_valid && in_ready;

   assign wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_a;
      end
   end

   // ------------------------------------------------------------------
   // Special-operand classification of the FIFO head
   // ------------------------------------------------------------------
   logic        byp_hit;
   logic [31:0] byp_val;

`ifdef PE_SQRT_SCHED_BYPASS_EN
   always_comb begin
      byp_hit = 1'b1;
      byp_val = 32'h0000_0000;
      if (fifo_head[30:23] == 8'h00) begin
         // +-0 and subnormals flush to a zero of the same sign.
         byp_val = {fifo_head[31], 31'h0};
      end else if (fifo_head[30:23] == 8'hff && fifo_head[22:0] != 23'h0) begin
         // NaN of either sign propagates, quieted.
         byp_val = fifo_head | 32'h0040_0000;
      end else if (fifo_head[31]) begin
         // Negative normals and -inf have no real root.
         byp_val = QNAN;
      end else if (fifo_head[30:23] == 8'hff) begin
         byp_val = 32'h7f80_0000;
      end else begin
         byp_hit = 1'b0;
      end
   end
`else
   assign byp_hit = 1'b0;
   assign byp_val = 32'h0000_0000;
`endif

   // ------------------------------------------------------------------
   // Launch / collect FSM
   // ------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [31:0]   core_a_q, core_a_d;
   logic          core_rst_q, core_rst_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_sqrt_q, out_sqrt_d;
   logic          out_err_q, out_err_d;
   logic [SW-1:0] load_cnt_q, load_cnt_d;
   logic [TW-1:0] wd_cnt_q, wd_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         core_a_q    <= 32'h0;
         core_rst_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sqrt_q  <= 32'h0;
         out_err_q   <= 1'b0;
         load_cnt_q  <= '0;
         wd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         core_a_q    <= core_a_d;
         core_rst_q  <= core_rst_d;
         out_valid_q <= out_valid_d;
         out_sqrt_q  <= out_sqrt_d;
         out_err_q   <= out_err_d;
         load_cnt_q  <= load_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      core_a_d    = core_a_q;
      out_valid_d = out_valid_q;
      out_sqrt_d  = out_sqrt_q;
      out_err_d   = out_err_q;
      load_cnt_d  = load_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      pop         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               core_a_d = fifo_head;
               if (byp_hit) begin
                  out_sqrt_d  = byp_val;
                  out_err_d   = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = S_HOLD;
               end else begin
                  load_cnt_d = '0;
                  state_d    = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            // core_rdy is deliberately ignored while the core is restarting.
            if (load_cnt_q == SW'(START_CYCLES - 1)) begin
               wd_cnt_d = '0;
               state_d  = S_WAIT;
            end else begin
               load_cnt_d = load_cnt_q + 1'b1;
            end
         end

         S_WAIT: begin
            // A ready core takes priority over an expiring watchdog.
            if (core_rdy) begin
               out_sqrt_d  = core_sqrt;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
               out_sqrt_d  = QNAN;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            // Returning through IDLE guarantees at least one idle cycle
            // between consecutive results.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The core runs only while in WAIT; registering this keeps core_rst
      // glitch-free and aligned with the state change.
      core_rst_d = (state_d != S_WAIT);
   end

   assign core_a    = core_a_q;
   assign core_rst  = core_rst_q;
   assign out_valid = out_valid_q;
   assign out_sqrt  = out_sqrt_q;
   assign out_err   = out_err_q;
   assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: doc/pe_sqrt_sched.md
# pe_sqrt_sched

Upstream issue/collect stage for `squareroot_f32_approximation`. Accepts a stream of IEEE-754 float32 operands on a valid/ready interface, buffers them in a small FIFO and starts the iterative square-root core once per operand by pulsing the core's `rst`. It waits for core `rdy`, captures `sqrt` and presents it on a valid/ready result port. Special operands bypass the core, and a watchdog bounds each core run.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `START_CYCLES`, 1: cycles `core_rst` is held high per launch; ≥1.
- `TIMEOUT`, 1023: maximum WAIT cycles before abort; ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: operand accepted when `in_valid & in_ready`.
- `in_a` in 32: float32 operand.
- `core_a` out 32: operand to core `a`.
- `core_rst` out 1: core `rst`; high means the core is idle or restarting.
- `core_rdy` in 1: core `rdy`.
- `core_sqrt` in 32: core `sqrt`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `out_sqrt` out 32: float32 result.
- `out_err` out 1: result came from a watchdog abort.
- `busy` out 1: FSM not IDLE, or FIFO not empty.

## Operation
- FIFO: circular, with `FIFO_DEPTH` entries. `in_ready = !full`. Push and pop in the same cycle are both honoured.
- FSM states: IDLE, LOAD, WAIT, HOLD.
- IDLE: `core_rst` = 1. If the FIFO is non-empty, pop the head and register it into `core_a`.
  - Special operand (see Configuration): form the result and go to HOLD.
  - Otherwise go to LOAD.
- LOAD: `core_rst` = 1 for exactly `START_CYCLES` cycles, then go to WAIT. `core_rdy` is ignored in LOAD.
- WAIT: `core_rst` = 0; the watchdog counter increments each cycle.
  - `core_rdy` = 1: capture `core_sqrt` into `out_sqrt`, `out_err` = 0, go to HOLD.
  - Counter reaches `TIMEOUT` without `rdy`: `out_sqrt` = 0x7fc00000, `out_err` = 1, go to HOLD.
  - `rdy` and timeout in the same cycle: `rdy` wins.
- HOLD: `core_rst` = 1, `out_valid` = 1, output stable. On `out_ready`, go to IDLE. The next FIFO entry is popped no earlier than the following cycle.
- `core_a` is held constant from pop until the FSM leaves WAIT.
- Reset mid-operation: FIFO flushed, FSM to IDLE, in-flight result discarded, `core_rst` forced to 1 asynchronously.
- Reset values: `in_ready` = 0 while `rst` is high, then 1 (FIFO empty). `core_a` = 0, `core_rst` = 1, `out_valid` = 0, `out_sqrt` = 0, `out_err` = 0, `busy` = 0.

## Timing
- Operand accepted at edge N, FIFO previously empty, FSM in IDLE: popped at edge N+1. LOAD covers edges N+2 … N+1+`START_CYCLES`; WAIT is entered on the next edge.
- `core_rdy` sampled high at edge E: `out_valid` rises after edge E (visible in cycle E+1).
- Bypass path: `out_valid` visible 2 cycles after acceptance.
- Watchdog: `out_valid` after exactly `TIMEOUT` WAIT cycles.
- Throughput: one operand in flight. Back-to-back results are separated by at least 1 IDLE cycle.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state.

## Configuration
- `PE_SQRT_SCHED_BYPASS_EN` defined — special operands resolve in IDLE without touching the core:
  - ±0 and subnormals → signed zero (0x00000000 / 0x80000000).
  - Negative nonzero → 0x7fc00000.
  - +inf → 0x7f800000.
  - NaN → input with the quiet bit set.
  - `out_err` = 0 for all of these.
- Undefined: every operand goes through LOAD/WAIT; the core's result, or the watchdog, decides the output.

## Test plan
- 0x40000000; core model raises `rdy` 20 cycles after `rst` falls and returns 0x3fb504f3 → `out_sqrt` = 0x3fb504f3, `out_err` = 0, `out_valid` in the cycle after `rdy`.
- With bypass: 0xbf800000, 0x80000000, 0x7f800000 → 0x7fc00000, 0x80000000, 0x7f800000, each 2 cycles after acceptance. `core_rst` never falls.
- `FIFO_DEPTH` = 4, `out_ready` held 0, 6 operands offered back-to-back → 5 accepted (1 in HOLD, 4 queued). `in_ready` = 0 from the 6th. Releasing `out_ready` drains results in order.
- `TIMEOUT` = 16, core never asserts `rdy` → after 16 WAIT cycles `out_sqrt` = 0x7fc00000, `out_err` = 1.
- `rst` pulsed during WAIT with 2 queued → `out_valid` = 0, `busy` = 0, `core_rst` = 1 immediately. The next operand after release runs normally.
- `rdy` coincident with the timeout edge → core value returned, `out_err` = 0.
